// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB.
// Issues loads/stores on a req/gnt/rvalid data port, lane-aligns store data,
// extends load data and registers the writeback result.
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses trap without a memory request
//   undefined -> misaligned low address bits are forced to zero and the access proceeds
//
// state | meaning
// IDLE  | no transaction; ALU results pass to WB, loads/stores are accepted
// REQ   | dmem_req_o high, request fields held until dmem_gnt_i
// RESP  | load granted, waiting up to WAIT_MAX cycles for dmem_rvalid_i
module mem_stage #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_result_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic        ex_is_load_i,
  input  logic        ex_is_store_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_reg_write_i,
  output logic        mem_stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        wb_reg_write_o,
  output logic        wb_err_o
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q;
  logic          rw_q;

  logic          wb_valid_q, wb_err_q, wb_rw_q;
  logic [4:0]    wb_rd_q;
  logic [31:0]   wb_data_q;

  logic          is_ls, f3_illegal, misaligned, trap;
  logic [31:0]   addr_eff, wdata_new;
  logic [3:0]    be_new;
  logic          timeout;

  logic          accept, wb_fire, wb_err_d, wb_rw_d;
  logic [4:0]    wb_rd_d;
  logic [31:0]   wb_data_d;

  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_ext;

  assign is_ls   = ex_is_load_i | ex_is_store_i;
  assign timeout = (cnt_q == CW'(WAIT_MAX - 1));

  assign mem_stall_o = (state_q != S_IDLE) | (ex_valid_i & is_ls);

  // Decode the incoming access: legality, alignment, effective address and store lanes
  always_comb begin
    if (ex_is_load_i) f3_illegal = (ex_funct3_i == 3'b011) | (ex_funct3_i[2:1] == 2'b11);
    else              f3_illegal = (ex_funct3_i > 3'b010);
    misaligned = ((ex_funct3_i[1:0] == 2'b01) & ex_result_i[0]) |
                 ((ex_funct3_i[1:0] == 2'b10) & (|ex_result_i[1:0]));
    addr_eff = ex_result_i;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = f3_illegal | misaligned;
`else
    trap = f3_illegal;
    if (misaligned) begin
      if (ex_funct3_i[1:0] == 2'b01) addr_eff[0]   = 1'b0;
      else                           addr_eff[1:0] = 2'b00;
    end
`endif
    unique case (ex_funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr_eff[1:0];
        wdata_new = {4{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << addr_eff[1:0];
        wdata_new = {2{ex_store_data_i[15:0]}};
      end
      default: begin
        be_new    = 4'hF;
        wdata_new = ex_store_data_i;
      end
    endcase
  end

  // Select and extend the returned load lane
  always_comb begin
    lane_b = dmem_rdata_i[8*addr_q[1:0] +: 8];
    lane_h = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    unique case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ex_valid_i && is_ls && !trap) state_d = S_REQ;
      S_REQ:   if (dmem_gnt_i) state_d = we_q ? S_IDLE : S_RESP;
      S_RESP:  if (dmem_rvalid_i || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath control: what to latch and what to present to WB next cycle
  always_comb begin
    accept    = 1'b0;
    wb_fire   = 1'b0;
    wb_err_d  = 1'b0;
    wb_rw_d   = wb_rw_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    cnt_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ex_valid_i) begin
          wb_rd_d = ex_rd_i;
          if (!is_ls) begin
            wb_fire   = 1'b1;
            wb_data_d = ex_result_i;
            wb_rw_d   = ex_reg_write_i & (ex_rd_i != 5'd0);
          end else if (trap) begin
            wb_fire  = 1'b1;
            wb_err_d = 1'b1;
            wb_rw_d  = 1'b0;
          end else begin
            accept  = 1'b1;
            wb_rd_d = wb_rd_q;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i && we_q) begin
          wb_fire = 1'b1;
          wb_rd_d = rd_q;
          wb_rw_d = 1'b0;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_rvalid_i) begin
          wb_fire   = 1'b1;
          wb_rd_d   = rd_q;
          wb_rw_d   = rw_q;
          wb_data_d = load_ext;
        end else if (timeout) begin
          wb_fire  = 1'b1;
          wb_err_d = 1'b1;
          wb_rd_d  = rd_q;
          wb_rw_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Holding registers, request strobe, wait counter and WB outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      req_q      <= (state_d == S_REQ);
      wb_valid_q <= wb_fire;
      wb_err_q   <= wb_err_d;
      wb_rw_q    <= wb_rw_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      if (accept) begin
        we_q    <= ~ex_is_load_i;
        addr_q  <= addr_eff;
        wdata_q <= wdata_new;
        be_q    <= be_new;
        f3_q    <= ex_funct3_i;
        rd_q    <= ex_rd_i;
        rw_q    <= ex_reg_write_i & (ex_rd_i != 5'd0);
      end
    end
  end

  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_wdata_o   = wdata_q;
  assign dmem_be_o      = be_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_err_o       = wb_err_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign wb_reg_write_o = wb_rw_q;

endmodule
